// File: rtl/mult_arbiter.sv
// mult_arbiter
//   Shares a single multiplier between N_CLI clients. Requests are granted
//   round-robin, one operation at a time. The granted client's operands are
//   latched and issued with a one-cycle start pulse. The arbiter then waits for
//   the multiplier's done pulse and returns the product to that client. A
//   watchdog turns a hung multiplier into an error response.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   cli_req       per-client request level
//   cli_data_req  packed operands, client i at [i*2W +: 2W], {multiplicand, multiplier}
//   cli_ack       one-hot completion pulse (1 cycle)
//   cli_data_ack  product, valid while cli_ack is nonzero
//   cli_err       set together with cli_ack when the operation timed out
//   mul_req       1-cycle start pulse to the multiplier
//   mul_data_req  operands latched from the granted client
//   mul_ack       multiplier done pulse
//   mul_data_ack  multiplier product, valid with mul_ack
module mult_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned N_CLI      = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_CLI-1:0]              cli_req,
    input  logic [N_CLI*2*DATA_WIDTH-1:0] cli_data_req,
    output logic [N_CLI-1:0]              cli_ack,
    output logic [2*DATA_WIDTH-1:0]       cli_data_ack,
    output logic                          cli_err,
    output logic                          mul_req,
    output logic [2*DATA_WIDTH-1:0]       mul_data_req,
    input  logic                          mul_ack,
    input  logic [2*DATA_WIDTH-1:0]       mul_data_ack
);

    localparam int unsigned OW = 2 * DATA_WIDTH;
    localparam int unsigned GW = (N_CLI > 1) ? $clog2(N_CLI) : 1;
    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     gnt_q, gnt_d;
    logic [GW-1:0]     last_grant_q, last_grant_d;
    logic [WW-1:0]     wdog_q, wdog_d;
    logic [N_CLI-1:0]  cli_ack_q, cli_ack_d;
    logic [OW-1:0]     cli_data_ack_q, cli_data_ack_d;
    logic              cli_err_q, cli_err_d;
    logic              mul_req_q, mul_req_d;
    logic [OW-1:0]     mul_data_req_q, mul_data_req_d;

    // Round-robin search result
    logic              found;
    logic [GW-1:0]     pick;
    logic [GW-1:0]     cand_idx;
    logic [OW-1:0]     pick_ops;
    logic [N_CLI-1:0]  gnt_onehot;

    // Search upward from the client after the last winner, wrapping; the first
    // requester found wins.
    always_comb begin
        found    = 1'b0;
        pick     = last_grant_q;
        cand_idx = '0;
        pick_ops = '0;
        for (int unsigned off = 1; off <= N_CLI; off++) begin
            cand_idx = GW'((32'(last_grant_q) + off) % N_CLI);
            if (!found && cli_req[cand_idx]) begin
                found = 1'b1;
                pick  = cand_idx;
            end
        end
        for (int unsigned i = 0; i < N_CLI; i++) begin
            if (GW'(i) == pick) begin
                pick_ops = cli_data_req[i*OW +: OW];
            end
        end
    end

    assign gnt_onehot = {{(N_CLI-1){1'b0}}, 1'b1} << gnt_q;

    // Response outputs default to zero so they are high only during RESP.
    always_comb begin
        state_d        = state_q;
        gnt_d          = gnt_q;
        last_grant_d   = last_grant_q;
        wdog_d         = wdog_q;
        cli_ack_d      = '0;
        cli_data_ack_d = '0;
        cli_err_d      = 1'b0;
        mul_req_d      = 1'b0;
        mul_data_req_d = mul_data_req_q;

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d          = pick;
                    mul_data_req_d = pick_ops;
                    mul_req_d      = 1'b1;
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                wdog_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // An ack arriving on the timeout cycle takes priority.
                if (mul_ack) begin
                    cli_ack_d      = gnt_onehot;
                    cli_data_ack_d = mul_data_ack;
                    state_d        = RESP;
                end else if (wdog_q == WW'(TIMEOUT - 1)) begin
                    cli_ack_d = gnt_onehot;
                    cli_err_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            RESP: begin
                last_grant_d = gnt_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            gnt_q          <= '0;
            last_grant_q   <= GW'(N_CLI - 1);
            wdog_q         <= '0;
            cli_ack_q      <= '0;
            cli_data_ack_q <= '0;
            cli_err_q      <= 1'b0;
            mul_req_q      <= 1'b0;
            mul_data_req_q <= '0;
        end else begin
            state_q        <= state_d;
            gnt_q          <= gnt_d;
            last_grant_q   <= last_grant_d;
            wdog_q         <= wdog_d;
            cli_ack_q      <= cli_ack_d;
            cli_data_ack_q <= cli_data_ack_d;
            cli_err_q      <= cli_err_d;
            mul_req_q      <= mul_req_d;
            mul_data_req_q <= mul_data_req_d;
        end
    end

    assign cli_ack      = cli_ack_q;
    assign cli_data_ack = cli_data_ack_q;
    assign cli_err      = cli_err_q;
    assign mul_req      = mul_req_q;
    assign mul_data_req = mul_data_req_q;

endmodule
